// File: rtl/kb_pkg.sv
// Shared constants, decoder state encoding and the shift-aware scan-code lookup
// used by the PS/2 keyboard decoder.
package kb_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        DEC_NORMAL    = 2'd0,
        DEC_BREAK     = 2'd1,
        DEC_EXT       = 2'd2,
        DEC_EXT_BREAK = 2'd3
    } dec_state_e;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_e;

    // US layout, set 2 make codes; zero means "no event for this code".
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
        logic [7:0] res;
        res = 8'h00;
        case (code)
            8'h1C: res = shift ? "A" : "a";
            8'h32: res = shift ? "B" : "b";
            8'h21: res = shift ? "C" : "c";
            8'h23: res = shift ? "D" : "d";
            8'h24: res = shift ? "E" : "e";
            8'h2B: res = shift ? "F" : "f";
            8'h34: res = shift ? "G" : "g";
            8'h33: res = shift ? "H" : "h";
            8'h43: res = shift ? "I" : "i";
            8'h3B: res = shift ? "J" : "j";
            8'h42: res = shift ? "K" : "k";
            8'h4B: res = shift ? "L" : "l";
            8'h3A: res = shift ? "M" : "m";
            8'h31: res = shift ? "N" : "n";
            8'h44: res = shift ? "O" : "o";
            8'h4D: res = shift ? "P" : "p";
            8'h15: res = shift ? "Q" : "q";
            8'h2D: res = shift ? "R" : "r";
            8'h1B: res = shift ? "S" : "s";
            8'h2C: res = shift ? "T" : "t";
            8'h3C: res = shift ? "U" : "u";
            8'h2A: res = shift ? "V" : "v";
            8'h1D: res = shift ? "W" : "w";
            8'h22: res = shift ? "X" : "x";
            8'h35: res = shift ? "Y" : "y";
            8'h1A: res = shift ? "Z" : "z";
            8'h45: res = shift ? ")" : "0";
            8'h16: res = shift ? "!" : "1";
            8'h1E: res = shift ? "@" : "2";
            8'h26: res = shift ? "#" : "3";
            8'h25: res = shift ? "$" : "4";
            8'h2E: res = shift ? "%" : "5";
            8'h36: res = shift ? "^" : "6";
            8'h3D: res = shift ? "&" : "7";
            8'h3E: res = shift ? "*" : "8";
            8'h46: res = shift ? "(" : "9";
            8'h29: res = 8'h20;
            8'h5A: res = 8'h0D;
            8'h66: res = 8'h08;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit frame
// capture with odd-parity/stop checking and a mid-frame inactivity timeout.
module ps2_frame_rx
    import kb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    rx_state_e              state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   frame_err_q, frame_err_d;

    logic clk_s, data_s, fall, good;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = dat_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~clk_s;
    assign good   = (^{shreg_q, par_q}) & data_s;

    always_comb begin
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d   = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d   = clk_s;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        tmo_d        = tmo_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                tmo_d = '0;
                if (fall && !data_s) begin
                    state_d   = RX_SHIFT;
                    bit_cnt_d = 4'd0;
                end
            end
            RX_SHIFT: begin
                if (fall) begin
                    tmo_d = '0;
                    if (bit_cnt_q < 4'd8) begin
                        shreg_d   = {data_s, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (bit_cnt_q == 4'd8) begin
                        par_d     = data_s;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else begin
                        state_d      = RX_IDLE;
                        byte_valid_d = good;
                        frame_err_d  = ~good;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = RX_IDLE;
                    tmo_d       = '0;
                    frame_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_sync_q   <= '1;
            dat_sync_q   <= '1;
            clk_prev_q   <= 1'b1;
            state_q      <= RX_IDLE;
            bit_cnt_q    <= 4'd0;
            shreg_q      <= 8'h00;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            clk_prev_q   <= clk_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = shreg_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_kb_decoder.sv
// PS/2 keyboard decoder top: make/break/extended tracking, shift state and the
// registered key-press event outputs feeding the text-mode logic.
module ps2_kb_decoder
    import kb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       kb_valid,
    output logic [7:0] ascii_code,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       rx_err;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .clk       (clk),
        .rstn      (rstn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (rx_err)
    );

    dec_state_e state_q, state_d;
    logic       shift_q, shift_d;
    logic       kb_valid_q, kb_valid_d;
    logic [7:0] ascii_q, ascii_d;
    logic [7:0] scan_q, scan_d;
    logic [7:0] lut;
    logic       is_shift;

    assign lut      = scan_to_ascii(byte_data, shift_q);
    assign is_shift = (byte_data == PS2_LSHIFT) || (byte_data == PS2_RSHIFT);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        kb_valid_d = 1'b0;
        ascii_d    = ascii_q;
        scan_d     = scan_q;
        if (rx_err) begin
            state_d = DEC_NORMAL;
        end else if (byte_valid) begin
            case (state_q)
                DEC_NORMAL: begin
                    if (byte_data == PS2_EXT) begin
                        state_d = DEC_EXT;
                    end else if (byte_data == PS2_BRK) begin
                        state_d = DEC_BREAK;
                    end else if (is_shift) begin
                        shift_d = 1'b1;
                    end else if (lut != 8'h00) begin
                        kb_valid_d = 1'b1;
                        scan_d     = byte_data;
                        ascii_d    = lut;
                    end
                end
                DEC_BREAK: begin
                    if (is_shift) shift_d = 1'b0;
                    state_d = DEC_NORMAL;
                end
                // Extended keys are swallowed; only their break prefix needs tracking.
                DEC_EXT: state_d = (byte_data == PS2_BRK) ? DEC_EXT_BREAK : DEC_NORMAL;
                default: state_d = DEC_NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= DEC_NORMAL;
            shift_q    <= 1'b0;
            kb_valid_q <= 1'b0;
            ascii_q    <= 8'h00;
            scan_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            kb_valid_q <= kb_valid_d;
            ascii_q    <= ascii_d;
            scan_q     <= scan_d;
        end
    end

    assign kb_valid   = kb_valid_q;
    assign ascii_code = ascii_q;
    assign scan_code  = scan_q;
    assign frame_err  = rx_err;

endmodule

// File: tb/tb_ps2_kb_decoder.sv
// Directed bench for ps2_kb_decoder: bit-banged PS/2 frames, event logging monitor
// and per-scenario inline checks.
module tb_ps2_kb_decoder;

    localparam int TMO  = 100;
    localparam int HALF = 6;

    logic       clk;
    logic       rstn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       kb_valid;
    logic [7:0] ascii_code;
    logic [7:0] scan_code;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int kb_cnt = 0;
    int fe_cnt = 0;
    int consec = 0;
    int kb_cyc = 0;
    int stop_fall_cyc = 0;
    logic prev_kb = 1'b0;
    logic [7:0] ascii_log[$];
    logic [7:0] scan_log[$];

    ps2_kb_decoder #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .kb_valid  (kb_valid),
        .ascii_code(ascii_code),
        .scan_code (scan_code),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (kb_valid) begin
                kb_cnt++;
                kb_cyc = cyc;
                ascii_log.push_back(ascii_code);
                scan_log.push_back(scan_code);
                if (prev_kb) consec++;
            end
            if (frame_err) fe_cnt++;
            prev_kb = kb_valid;
        end else begin
            prev_kb = 1'b0;
        end
    end

    task automatic send_bit(input logic b, input logic is_stop);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (is_stop) stop_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
        send_bit((~^b) ^ par_flip, 1'b0);
        send_bit(1'b1, 1'b1);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic clear_logs();
        kb_cnt = 0;
        fe_cnt = 0;
        ascii_log.delete();
        scan_log.delete();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (kb_valid !== 1'b0) begin errors++; $display("FAIL reset_kb_valid: got %b want 0", kb_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++; if (ascii_code !== 8'h00) begin errors++; $display("FAIL reset_ascii: got %h want 00", ascii_code); end
        checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL reset_scan: got %h want 00", scan_code); end
        rstn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        clear_logs();
        send_frame(8'h1C, 1'b0);
        checks++; if (kb_cnt !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", kb_cnt); end
        checks++; if (scan_code !== 8'h1C) begin errors++; $display("FAIL single_scan: got %h want 1c", scan_code); end
        checks++; if (ascii_code !== 8'h61) begin errors++; $display("FAIL single_ascii: got %h want 61", ascii_code); end
        checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL single_frame_err: got %0d want 0", fe_cnt); end
        checks++; if (kb_cyc - stop_fall_cyc !== 4) begin errors++; $display("FAIL single_latency: got %0d want 4", kb_cyc - stop_fall_cyc); end
    endtask

    task automatic test_shift_sequence();
        logic [7:0] seq[7] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
        clear_logs();
        foreach (seq[i]) send_frame(seq[i], 1'b0);
        checks++; if (kb_cnt !== 2) begin errors++; $display("FAIL shift_count: got %0d want 2", kb_cnt); end
        if (ascii_log.size() == 2) begin
            checks++; if (ascii_log[0] !== 8'h41) begin errors++; $display("FAIL shift_first_ascii: got %h want 41", ascii_log[0]); end
            checks++; if (ascii_log[1] !== 8'h61) begin errors++; $display("FAIL shift_second_ascii: got %h want 61", ascii_log[1]); end
            checks++; if (scan_log[0] !== 8'h1C) begin errors++; $display("FAIL shift_first_scan: got %h want 1c", scan_log[0]); end
        end
    endtask

    task automatic test_extended();
        logic [7:0] seq[6] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h16};
        clear_logs();
        foreach (seq[i]) send_frame(seq[i], 1'b0);
        checks++; if (kb_cnt !== 1) begin errors++; $display("FAIL ext_count: got %0d want 1", kb_cnt); end
        checks++; if (scan_code !== 8'h16) begin errors++; $display("FAIL ext_scan: got %h want 16", scan_code); end
        checks++; if (ascii_code !== 8'h31) begin errors++; $display("FAIL ext_ascii: got %h want 31", ascii_code); end
    endtask

    task automatic test_parity_err();
        clear_logs();
        send_frame(8'h1C, 1'b1);
        checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL parity_frame_err: got %0d want 1", fe_cnt); end
        checks++; if (kb_cnt !== 0) begin errors++; $display("FAIL parity_no_event: got %0d want 0", kb_cnt); end
        checks++; if (ascii_code !== 8'h31) begin errors++; $display("FAIL parity_ascii_held: got %h want 31", ascii_code); end
        checks++; if (scan_code !== 8'h16) begin errors++; $display("FAIL parity_scan_held: got %h want 16", scan_code); end
        send_frame(8'h29, 1'b0);
        checks++; if (kb_cnt !== 1) begin errors++; $display("FAIL parity_recover_count: got %0d want 1", kb_cnt); end
        checks++; if (ascii_code !== 8'h20) begin errors++; $display("FAIL parity_recover_ascii: got %h want 20", ascii_code); end
    endtask

    task automatic test_timeout();
        clear_logs();
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        repeat (TMO + 50) @(negedge clk);
        checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL timeout_frame_err: got %0d want 1", fe_cnt); end
        checks++; if (kb_cnt !== 0) begin errors++; $display("FAIL timeout_no_event: got %0d want 0", kb_cnt); end
        send_frame(8'h5A, 1'b0);
        checks++; if (kb_cnt !== 1) begin errors++; $display("FAIL timeout_recover_count: got %0d want 1", kb_cnt); end
        checks++; if (ascii_code !== 8'h0D) begin errors++; $display("FAIL timeout_recover_ascii: got %h want 0d", ascii_code); end
        checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL timeout_single_err: got %0d want 1", fe_cnt); end
    endtask

    task automatic test_misc_keys();
        logic [7:0] seq[6] = '{8'h59, 8'h16, 8'hF0, 8'h59, 8'hAA, 8'h66};
        clear_logs();
        foreach (seq[i]) send_frame(seq[i], 1'b0);
        checks++; if (kb_cnt !== 2) begin errors++; $display("FAIL misc_count: got %0d want 2", kb_cnt); end
        if (ascii_log.size() == 2) begin
            checks++; if (ascii_log[0] !== 8'h21) begin errors++; $display("FAIL misc_rshift_digit: got %h want 21", ascii_log[0]); end
            checks++; if (ascii_log[1] !== 8'h08) begin errors++; $display("FAIL misc_backspace: got %h want 08", ascii_log[1]); end
        end
    endtask

    task automatic test_reset_midframe();
        clear_logs();
        send_frame(8'h12, 1'b0);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++; if (kb_valid !== 1'b0) begin errors++; $display("FAIL midrst_kb_valid: got %b want 0", kb_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err: got %b want 0", frame_err); end
        checks++; if (ascii_code !== 8'h00) begin errors++; $display("FAIL midrst_ascii: got %h want 00", ascii_code); end
        checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL midrst_scan: got %h want 00", scan_code); end
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        clear_logs();
        send_frame(8'h1C, 1'b0);
        checks++; if (kb_cnt !== 1) begin errors++; $display("FAIL midrst_recover_count: got %0d want 1", kb_cnt); end
        checks++; if (ascii_code !== 8'h61) begin errors++; $display("FAIL midrst_recover_ascii: got %h want 61", ascii_code); end
        checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL midrst_no_err: got %0d want 0", fe_cnt); end
    endtask

    task automatic test_back_to_back();
        checks++; if (consec !== 0) begin errors++; $display("FAIL kb_valid_consecutive: got %0d want 0", consec); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_shift_sequence();
        test_extended();
        test_parity_err();
        test_timeout();
        test_misc_keys();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
